// File: rtl/mem_responder_pkg.sv
// Shared types and default bus geometry for the memory responder and its requesters.
package mem_responder_pkg;

   localparam int DEF_ADDR_W      = 26;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_DEPTH_LOG2  = 10;
   localparam int DEF_WAIT_STATES = 2;
   localparam int WAIT_W          = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU data path (master) and the memory responder (slave).
interface mem_responder_if #(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 32
);
   logic              READ;
   logic              WRITE;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] DATA_IN;
   logic [DATA_W-1:0] DATA_OUT;
   logic              DONE;
   logic              ERR;
   logic              BUSY;

   modport master (
      output READ, WRITE, ADDR, DATA_IN,
      input  DATA_OUT, DONE, ERR, BUSY
   );

   modport slave (
      input  READ, WRITE, ADDR, DATA_IN,
      output DATA_OUT, DONE, ERR, BUSY
   );
endinterface

// File: rtl/mem_resp_array.sv
// Single-port synchronous word array with a registered read port.
// The storage is never reset; only the read register returns to zero.
module mem_resp_array #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);

   logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
   logic [DATA_W-1:0] rdata_q;

   // Array write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read register: holds the last read word until the next read
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: accepts one request, waits WAIT_STATES cycles,
// performs the access on the word array and pulses DONE (with ERR on bad requests).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
   parameter int WAIT_STATES = DEF_WAIT_STATES
) (
   input  logic            CLK,
   input  logic            RST,
   mem_responder_if.slave  bus
);

   localparam logic [WAIT_W-1:0] WS_L = WAIT_W'(WAIT_STATES);

   state_t              state_q;
   logic [WAIT_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                rd_q;
   logic                wr_q;
   logic                done_q;
   logic                err_q;
   logic                busy_q;

   logic                req_err_d;
   logic                access_d;
   logic                we_d;
   logic                re_d;
   logic [DATA_W-1:0]   rdata_d;

   // Error decode and array strobes; reset suppresses an access on the same edge
   always_comb begin
      req_err_d = (rd_q & wr_q) | (|addr_q[ADDR_W-1:DEPTH_LOG2]);
      access_d  = 1'b0;
      if ((state_q == S_BUSY) && (cnt_q == {WAIT_W{1'b0}}) && !req_err_d && !RST) begin
         access_d = 1'b1;
      end else begin
         access_d = 1'b0;
      end
      we_d = access_d & wr_q;
      re_d = access_d & rd_q;
   end

   // Request FSM with wait counter, request latches and registered status outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= {WAIT_W{1'b0}};
         addr_q  <= '0;
         data_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               if (bus.READ || bus.WRITE) begin
                  addr_q  <= bus.ADDR;
                  data_q  <= bus.DATA_IN;
                  rd_q    <= bus.READ;
                  wr_q    <= bus.WRITE;
                  cnt_q   <= WS_L;
                  busy_q  <= 1'b1;
                  state_q <= S_BUSY;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            S_BUSY: begin
               if (cnt_q != {WAIT_W{1'b0}}) begin
                  cnt_q <= cnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
               end else begin
                  done_q  <= 1'b1;
                  err_q   <= req_err_d;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   mem_resp_array #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk_i   (CLK),
      .rst_i   (RST),
      .we_i    (we_d),
      .re_i    (re_d),
      .addr_i  (addr_q[DEPTH_LOG2-1:0]),
      .wdata_i (data_q),
      .rdata_o (rdata_d)
   );

   assign bus.DATA_OUT = rdata_d;
   assign bus.DONE     = done_q;
   assign bus.ERR      = err_q;
   assign bus.BUSY     = busy_q;

endmodule
